// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : btn_conditioner
//  Purpose  : Synchronises and debounces one active-low push-button and emits
//             single-cycle press / release / short / long (and optional
//             auto-repeat) events. Optional feature macro: BTN_AUTOREPEAT_EN.
//  Revision : 1.0  - initial release
// ============================================================================
module btn_conditioner #(
    parameter int P_DEBOUNCE_CYCLES = 500000,
    parameter int P_LONG_CYCLES     = 50000000,
    parameter int P_REPEAT_CYCLES   = 10000000
) (
    input  logic CLK1,
    input  logic RST,
    input  logic BTN_N,
    output logic PRESSED,
    output logic PRESS_PULSE,
    output logic RELEASE_PULSE,
    output logic SHORT_PULSE,
    output logic LONG_PULSE,
    output logic REPEAT_PULSE
);

    localparam int c_DEB_W  = $clog2(P_DEBOUNCE_CYCLES + 1);
    localparam int c_HOLD_W = $clog2(P_LONG_CYCLES + 1);

    // Debounce counter reaches this value on the last required stable sample.
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST = c_DEB_W'(P_DEBOUNCE_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_LONG_MAX = c_HOLD_W'(P_LONG_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PRESS_WAIT = 3'd1,
        S_HELD       = 3'd2,
        S_LONG_HELD  = 3'd3,
        S_REL_WAIT   = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_sync_meta;
    logic                  r_sync;
    logic [c_DEB_W-1:0]    r_deb_cnt;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic                  r_long_seen;
    logic                  r_pressed;
    logic                  r_press_pulse;
    logic                  r_release_pulse;
    logic                  r_short_pulse;
    logic                  r_long_pulse;
    logic                  w_s;
    logic [c_HOLD_W-1:0]   w_hold_next;

`ifdef BTN_AUTOREPEAT_EN
    localparam int c_REP_W = $clog2(P_REPEAT_CYCLES + 1);
    localparam logic [c_REP_W-1:0] c_REP_MAX = c_REP_W'(P_REPEAT_CYCLES);

    logic [c_REP_W-1:0]    r_rep_cnt;
    logic [c_REP_W-1:0]    w_rep_next;
    logic                  r_repeat_pulse;

    // Repeat counter saturates so a long REL_WAIT excursion can never wrap it.
    assign w_rep_next   = (r_rep_cnt >= c_REP_MAX) ? c_REP_MAX : r_rep_cnt + c_REP_W'(1);
    assign REPEAT_PULSE = r_repeat_pulse;
`else
    // Repeat logic absent; expression is constant 0 for any legal P_REPEAT_CYCLES.
    assign REPEAT_PULSE = (P_REPEAT_CYCLES < 0);
`endif

    assign w_s = r_sync;

    // Hold counter saturates at the long threshold; holding forever cannot wrap.
    assign w_hold_next = (r_hold_cnt >= c_LONG_MAX) ? c_LONG_MAX : r_hold_cnt + c_HOLD_W'(1);

    assign PRESSED       = r_pressed;
    assign PRESS_PULSE   = r_press_pulse;
    assign RELEASE_PULSE = r_release_pulse;
    assign SHORT_PULSE   = r_short_pulse;
    assign LONG_PULSE    = r_long_pulse;

    // Two-flop synchroniser; resets to the released level.
    always_ff @(posedge CLK1) begin
        if (RST) begin
            r_sync_meta <= 1'b1;
            r_sync      <= 1'b1;
        end else begin
            r_sync_meta <= BTN_N;
            r_sync      <= r_sync_meta;
        end
    end

    // Debounce / hold-time FSM with registered level and event outputs.
    always_ff @(posedge CLK1) begin
        if (RST) begin
            r_state         <= S_IDLE;
            r_deb_cnt       <= '0;
            r_hold_cnt      <= '0;
            r_long_seen     <= 1'b0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_short_pulse   <= 1'b0;
            r_long_pulse    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            r_rep_cnt       <= '0;
            r_repeat_pulse  <= 1'b0;
`endif
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_short_pulse   <= 1'b0;
            r_long_pulse    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            r_repeat_pulse  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!w_s) begin
                        r_state   <= S_PRESS_WAIT;
                        r_deb_cnt <= '0;
                    end
                end

                S_PRESS_WAIT: begin
                    if (w_s) begin
                        r_state <= S_IDLE;
                    end else if (r_deb_cnt >= c_DEB_LAST) begin
                        r_state       <= S_HELD;
                        r_press_pulse <= 1'b1;
                        r_pressed     <= 1'b1;
                        r_hold_cnt    <= '0;
                        r_long_seen   <= 1'b0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
                    end
                end

                S_HELD: begin
                    // The cycle still counts as held time; a release start
                    // wins over a long event landing on the same edge.
                    r_hold_cnt <= w_hold_next;
                    if (w_s) begin
                        r_state   <= S_REL_WAIT;
                        r_deb_cnt <= '0;
                    end else if (w_hold_next >= c_LONG_MAX) begin
                        r_state      <= S_LONG_HELD;
                        r_long_pulse <= 1'b1;
                        r_long_seen  <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        r_rep_cnt    <= '0;
`endif
                    end
                end

                S_LONG_HELD: begin
`ifdef BTN_AUTOREPEAT_EN
                    r_rep_cnt <= w_rep_next;
`endif
                    if (w_s) begin
                        r_state   <= S_REL_WAIT;
                        r_deb_cnt <= '0;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (w_rep_next >= c_REP_MAX) begin
                        r_repeat_pulse <= 1'b1;
                        r_rep_cnt      <= '0;
                    end
`endif
                end

                S_REL_WAIT: begin
                    // Hold and repeat counters stay frozen while deciding.
                    if (!w_s) begin
                        r_state <= r_long_seen ? S_LONG_HELD : S_HELD;
                    end else if (r_deb_cnt >= c_DEB_LAST) begin
                        r_state         <= S_IDLE;
                        r_release_pulse <= 1'b1;
                        r_short_pulse   <= ~r_long_seen;
                        r_pressed       <= 1'b0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
